// File: rtl/mac_vec_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mac_vec_accum_pipe
// Description : Pipelined, stream-driven vector multiply-accumulate.
//               Every accepted beat contributes a VEC-lane signed dot-product
//               chunk to an accumulator. The beat marked last closes the dot
//               product, whose result is rounded (half up), arithmetically
//               shifted right by FRAC_BITS and saturated to OUT_WIDTH bits.
//
//               S1 (acceptance edge)  : lane products summed, first/last/bias
//                                       captured.
//               S2 (following edge)   : accumulator / beat counter / FSM
//                                       update, output register load on last.
//
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active low
//               in_valid   - input beat valid
//               in_ready   - input beat accepted when in_valid & in_ready
//               in_a, in_b - VEC packed signed lanes, lane i at
//                            [i*DATA_WIDTH +: DATA_WIDTH]
//               in_first   - beat starts a new dot product
//               in_last    - beat ends the current dot product
//               bias       - signed, used with the first beat only
//               out_valid  - result valid
//               out_ready  - result consumed when out_valid & out_ready
//               out_data   - rounded, shifted, saturated result
//               out_sat    - out_data was clamped
//               out_beats  - beats contributing to this result (wrapping)
//
// Config      : `define MAC_RELU_EN to clamp negative shifted results to 0
//               before saturation (only positive overflow sets out_sat).
//
// Revision    : 1.0 - initial release
// ============================================================================
module mac_vec_accum_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 48,
  parameter int VEC         = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int FRAC_BITS   = 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [VEC*DATA_WIDTH-1:0]   in_a,
  input  logic [VEC*DATA_WIDTH-1:0]   in_b,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [ACCUM_WIDTH-1:0]      bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_sat,
  output logic [LEN_WIDTH-1:0]        out_beats
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Saturation bounds expressed at the one-bit-wider conversion width.
  localparam logic signed [ACCUM_WIDTH:0] c_out_max =
    {{(ACCUM_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH:0] c_out_min =
    {{(ACCUM_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Flow control: a pending, unconsumed result freezes the whole pipe.
  // --------------------------------------------------------------------------
  logic w_stall;
  logic r_out_valid;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // --------------------------------------------------------------------------
  // Lane products, each sign-extended to the accumulator width before summing.
  // --------------------------------------------------------------------------
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic        [ACCUM_WIDTH-1:0]  w_dot;

  always_comb begin
    w_dot  = '0;
    w_prod = '0;
    for (int i = 0; i < VEC; i++) begin
      w_prod = $signed(in_a[i*DATA_WIDTH +: DATA_WIDTH]) *
               $signed(in_b[i*DATA_WIDTH +: DATA_WIDTH]);
      w_dot  = w_dot + {{(ACCUM_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    end
  end

  // --------------------------------------------------------------------------
  // S1 register
  // --------------------------------------------------------------------------
  logic                   r_s1_valid;
  logic [ACCUM_WIDTH-1:0] r_s1_sum;
  logic                   r_s1_first;
  logic                   r_s1_last;
  logic [ACCUM_WIDTH-1:0] r_s1_bias;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_bias  <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sum   <= w_dot;
        r_s1_first <= in_first;
        r_s1_last  <= in_last;
        r_s1_bias  <= bias;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2 next-state: a beat arriving while IDLE starts a product even without
  // first, and first while RUN discards the partial sum.
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic [ACCUM_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic                   w_start;
  logic [ACCUM_WIDTH-1:0] w_acc_next;
  logic [LEN_WIDTH-1:0]   w_cnt_next;

  assign w_start    = r_s1_first | (r_state == ST_IDLE);
  assign w_acc_next = (w_start ? r_s1_bias : r_acc) + r_s1_sum;
  assign w_cnt_next = w_start ? LEN_WIDTH'(1) : r_cnt + LEN_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Output conversion of the closing sum: round half up, shift, clamp.
  // One extra bit keeps the rounding add from overflowing.
  // --------------------------------------------------------------------------
  logic signed [ACCUM_WIDTH:0] w_ext;
  logic signed [ACCUM_WIDTH:0] w_rounded;
  logic signed [ACCUM_WIDTH:0] w_shifted;
  logic signed [ACCUM_WIDTH:0] w_relu;
  logic [OUT_WIDTH-1:0]        w_conv_data;
  logic                        w_conv_sat;

  assign w_ext = {w_acc_next[ACCUM_WIDTH-1], w_acc_next};

  generate
    if (FRAC_BITS > 0) begin : g_round
      localparam logic signed [ACCUM_WIDTH:0] c_half =
        (ACCUM_WIDTH+1)'(1) << (FRAC_BITS-1);
      assign w_rounded = w_ext + c_half;
    end else begin : g_no_round
      assign w_rounded = w_ext;
    end
  endgenerate

  assign w_shifted = w_rounded >>> FRAC_BITS;

`ifdef MAC_RELU_EN
  // Negative results become zero before the clamp, so they never flag out_sat.
  assign w_relu = w_shifted[ACCUM_WIDTH] ? '0 : w_shifted;
`else
  assign w_relu = w_shifted;
`endif

  always_comb begin
    w_conv_data = w_relu[OUT_WIDTH-1:0];
    w_conv_sat  = 1'b0;
    if (w_relu > c_out_max) begin
      w_conv_data = c_out_max[OUT_WIDTH-1:0];
      w_conv_sat  = 1'b1;
    end else if (w_relu < c_out_min) begin
      w_conv_data = c_out_min[OUT_WIDTH-1:0];
      w_conv_sat  = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // S2 register: FSM, accumulator, counter and output register.
  // When not stalled, any previous result has just been consumed (or was
  // never valid), so out_valid simply follows whether a result loads now.
  // --------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_sat;
  logic [LEN_WIDTH-1:0] r_out_beats;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_beats <= '0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        if (r_s1_last) begin
          r_state     <= ST_IDLE;
          r_out_data  <= w_conv_data;
          r_out_sat   <= w_conv_sat;
          r_out_beats <= w_cnt_next;
        end else begin
          r_state <= ST_RUN;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_beats = r_out_beats;

endmodule
`default_nettype wire

// File: tb/tb_mac_vec_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_vec_accum_pipe
// Description : Self-checking bench for mac_vec_accum_pipe. Expected results
//               are queued when a product's beats are driven and compared in
//               order as the DUT hands them over. Honours MAC_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_vec_accum_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_a;
  logic [255:0] in_b;
  logic         in_first;
  logic         in_last;
  logic [47:0]  bias;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic         out_sat;
  logic [15:0]  out_beats;

  always #5 clk = ~clk;

  mac_vec_accum_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_beats (out_beats)
  );

  typedef struct {
    logic [15:0] data;
    logic        sat;
    logic [15:0] beats;
  } res_t;

  typedef struct {
    logic [15:0] a0, b0, ar, br;  // lane 0 and remaining lanes
    longint      bv;              // bias on the first beat
    int          nb;              // beats in the product
    logic [15:0] data;
    logic        sat;
    logic [15:0] beats;
  } vec_t;

  res_t q[$];
  vec_t tbl[14];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge, i.e. exactly what the next rising edge will see.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic s, input logic [15:0] b);
    res_t r;
    r.data = d; r.sat = s; r.beats = b;
    q.push_back(r);
  endtask

  task automatic send_beat(input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] ar, input logic [15:0] br,
                           input longint bv, input logic f, input logic l);
    int n;
    for (int i = 0; i < 16; i++) begin
      in_a[i*16 +: 16] = (i == 0) ? a0 : ar;
      in_b[i*16 +: 16] = (i == 0) ? b0 : br;
    end
    bias     = bv[47:0];
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(q.size()), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    push(v.data, v.sat, v.beats);
    for (int b = 0; b < v.nb; b++)
      send_beat(v.a0, v.b0, v.ar, v.br, (b == 0) ? v.bv : 64'sd12345, b == 0, b == v.nb - 1);
  endtask

  // Scoreboard: every handshake pops and compares the oldest expected result.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL result_unexpected: got data=%h sat=%b beats=%0d, expected no result",
                 out_data, out_sat, out_beats);
      end else begin
        res_t e;
        e = q.pop_front();
        if (out_data !== e.data || out_sat !== e.sat || out_beats !== e.beats) begin
          n_bad++;
          $display("FAIL result: got data=%h sat=%b beats=%0d, expected data=%h sat=%b beats=%0d",
                   out_data, out_sat, out_beats, e.data, e.sat, e.beats);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //               a0       b0       ar       br       bias         nb  data     sat   beats
    tbl[0]  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 0,           1, 16'd4096,  1'b0, 16'd1};
    tbl[1]  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 0,           3, 16'd12288, 1'b0, 16'd3};
    tbl[2]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0,           4, 16'h7FFF,  1'b1, 16'd4};
`ifdef MAC_RELU_EN
    tbl[3]  = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 0,           4, 16'h0000,  1'b0, 16'd4};
`else
    tbl[3]  = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 0,           4, 16'h8000,  1'b1, 16'd4};
`endif
    tbl[4]  = '{16'h0001, 16'd128,  16'h0000, 16'h0000, 0,           1, 16'd1,     1'b0, 16'd1};
    tbl[5]  = '{16'h0001, 16'd127,  16'h0000, 16'h0000, 0,           1, 16'd0,     1'b0, 16'd1};
    tbl[6]  = '{16'hFFFF, 16'd128,  16'h0000, 16'h0000, 0,           1, 16'd0,     1'b0, 16'd1};
    tbl[7]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 384,         1, 16'd2,     1'b0, 16'd1};
`ifdef MAC_RELU_EN
    tbl[8]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, -384,        1, 16'h0000,  1'b0, 16'd1};
`else
    tbl[8]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, -384,        1, 16'hFFFF,  1'b0, 16'd1};
`endif
    tbl[9]  = '{16'h0100, 16'h0100, 16'h0000, 16'h0000, 1000,        2, 16'd516,   1'b0, 16'd2};
    tbl[10] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 8388224,     1, 16'h7FFF,  1'b0, 16'd1};
    tbl[11] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 8388480,     1, 16'h7FFF,  1'b1, 16'd1};
`ifdef MAC_RELU_EN
    tbl[12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, -8388736,    1, 16'h0000,  1'b0, 16'd1};
    tbl[13] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, -8388737,    1, 16'h0000,  1'b0, 16'd1};
`else
    tbl[12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, -8388736,    1, 16'h8000,  1'b0, 16'd1};
    tbl[13] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, -8388737,    1, 16'h8000,  1'b1, 16'd1};
`endif

    // Reset state
    rst       = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    bias      = '0;
    idle();
    tick();
    tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_data",  64'(out_data),  64'd0);
    check("reset_out_sat",   64'(out_sat),   64'd0);
    check("reset_out_beats", 64'(out_beats), 64'd0);
    rst = 1'b1;
    tick();

    // Latency: result register loads on the edge after acceptance
    push(16'd4096, 1'b0, 16'd1);
    send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 1'b1, 1'b1);
    idle();
    check("latency_acc_edge",  64'(out_valid), 64'd0);
    tick();
    check("latency_next_edge", 64'(out_valid), 64'd1);
    drain("latency_drain");

    // Table vectors, streamed back to back
    for (int i = 0; i < 14; i++)
      run_vec(tbl[i]);
    idle();
    drain("table_drain");

    // First while RUN restarts; old partial sum and count dropped
    push(16'd1, 1'b0, 16'd2);
    send_beat(16'h0100, 16'h0100, 16'h0000, 16'h0000, 0,   1'b1, 1'b0);
    send_beat(16'h0100, 16'h0100, 16'h0000, 16'h0000, 0,   1'b0, 1'b0);
    send_beat(16'h0000, 16'h0000, 16'h0000, 16'h0000, 256, 1'b1, 1'b0);
    send_beat(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,   1'b0, 1'b1);
    idle();
    drain("restart_drain");

    // Beat without first while IDLE starts a product with its bias
    push(16'd2, 1'b0, 16'd1);
    send_beat(16'h0000, 16'h0000, 16'h0000, 16'h0000, 512, 1'b0, 1'b1);
    idle();
    drain("nofirst_drain");

    // Backpressure: two results complete while out_ready is low
    out_ready = 1'b0;
    push(16'd256, 1'b0, 16'd1);
    push(16'd5,   1'b0, 16'd1);
    send_beat(16'h0100, 16'h0100, 16'h0000, 16'h0000, 0,    1'b1, 1'b1);
    send_beat(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1280, 1'b1, 1'b1);
    idle();
    tick();
    check("stall_in_ready",  64'(in_ready),  64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_out_data",  64'(out_data),  64'd256);
    tick();
    tick();
    tick();
    check("stall_hold_data",  64'(out_data),  64'd256);
    check("stall_hold_beats", 64'(out_beats), 64'd1);
    check("stall_queue",      64'(q.size()),  64'd2);
    out_ready = 1'b1;
    drain("stall_drain");
    tick();
    check("stall_after_valid", 64'(out_valid), 64'd0);

    // Reset mid-product discards the partial sum
    send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 1'b1, 1'b0);
    send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 1'b0, 1'b0);
    idle();
    rst = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_in_ready",  64'(in_ready),  64'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    push(16'd256, 1'b0, 16'd1);
    send_beat(16'h0100, 16'h0100, 16'h0000, 16'h0000, 0, 1'b1, 1'b1);
    idle();
    drain("midreset_drain");
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
